// File: rtl/mmu_arb_pkg.sv
// Shared types and constants for the MMU / data / fetch DRAM arbiter.
package mmu_arb_pkg;

    // Width of the owner code carried on the owner port and by the picker.
    localparam int OWN_W = 2;

    // Arbiter sequencing: pick, strobe the command, skip one cycle, await completion.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_GUARD = 2'd2,
        ARB_WAIT  = 2'd3
    } arb_state_e;

    // Owner codes, also used as the picker's winner code.
    localparam logic [OWN_W-1:0] OWN_NONE = 2'd0;
    localparam logic [OWN_W-1:0] OWN_PTW  = 2'd1;
    localparam logic [OWN_W-1:0] OWN_DM   = 2'd2;
    localparam logic [OWN_W-1:0] OWN_IF   = 2'd3;

    // Full-word byte enables for requesters that carry no strobe of their own.
    localparam logic [3:0] WSTRB_FULL = 4'hF;

endpackage

// File: rtl/mmu_dram_arbiter_if.sv
// Requester and DRAM-controller signal bundle for mmu_dram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mmu_dram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mmu_arb_pkg::*;

    // Page-table walker
    logic              ptw_req;
    logic              ptw_we;
    logic [ADDR_W-1:0] ptw_addr;
    logic [DATA_W-1:0] ptw_wdata;
    logic              ptw_lock;
    logic              ptw_ack;
    logic              ptw_rvalid;

    // Data memory port
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_wstrb;
    logic              dm_ack;
    logic              dm_rvalid;

    // Instruction fetch
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              if_rvalid;

    // Shared return path and status
    logic [DATA_W-1:0] rdata;
    logic [OWN_W-1:0]  owner;

    // DRAM controller command side
    logic              dram_req;
    logic              dram_we;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic [3:0]        dram_wstrb;
    logic              dram_busy;
    logic [DATA_W-1:0] dram_odata;

    modport slave (
        input  ptw_req, ptw_we, ptw_addr, ptw_wdata, ptw_lock,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  if_req, if_addr,
        input  dram_busy, dram_odata,
        output ptw_ack, ptw_rvalid, dm_ack, dm_rvalid, if_ack, if_rvalid,
        output rdata, owner,
        output dram_req, dram_we, dram_addr, dram_wdata, dram_wstrb
    );

    modport master (
        output ptw_req, ptw_we, ptw_addr, ptw_wdata, ptw_lock,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output if_req, if_addr,
        output dram_busy, dram_odata,
        input  ptw_ack, ptw_rvalid, dm_ack, dm_rvalid, if_ack, if_rvalid,
        input  rdata, owner,
        input  dram_req, dram_we, dram_addr, dram_wdata, dram_wstrb
    );

endinterface

// File: rtl/mmu_arb_pick.sv
// Combinational winner selection for the DRAM arbiter.
// A page walk in progress (ptw_lock) shuts out DM and IF entirely; otherwise
// PTW > DM > IF, with IF promoted above DM once the starvation limit is hit.
module mmu_arb_pick
    import mmu_arb_pkg::*;
(
    input  logic             ptw_req,
    input  logic             dm_req,
    input  logic             if_req,
    input  logic             ptw_lock,
    input  logic             starve,
    output logic [OWN_W-1:0] owner
);

    // Priority pick with lock gating and starvation promotion of IF
    always_comb begin
        owner = OWN_NONE;
        if (ptw_lock) begin
            if (ptw_req) begin
                owner = OWN_PTW;
            end else begin
                owner = OWN_NONE;
            end
        end else if (ptw_req) begin
            owner = OWN_PTW;
        end else if (starve && if_req) begin
            owner = OWN_IF;
        end else if (dm_req) begin
            owner = OWN_DM;
        end else if (if_req) begin
            owner = OWN_IF;
        end else begin
            owner = OWN_NONE;
        end
    end

endmodule

// File: rtl/mmu_dram_arbiter.sv
// Single-port DRAM arbiter for PTW, data port and instruction fetch.
// One transaction at a time: IDLE picks a winner and latches its command,
// ISSUE strobes dram_req, GUARD lets the controller raise busy, WAIT returns
// data on busy low. Every output is registered.
module mmu_dram_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic               CLK,
    input logic               RST,
    mmu_dram_arbiter_if.slave bus
);

    localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e        state_r, state_nxt_s;
    logic [OWN_W-1:0]  pick_s;
    logic              starve_s;
    logic [CNT_W-1:0]  starve_cnt_r, starve_cnt_nxt_s, starve_inc_s;

    logic              ptw_ack_r, dm_ack_r, if_ack_r;
    logic              ptw_ack_nxt_s, dm_ack_nxt_s, if_ack_nxt_s;
    logic              ptw_rvalid_r, dm_rvalid_r, if_rvalid_r;
    logic              ptw_rvalid_nxt_s, dm_rvalid_nxt_s, if_rvalid_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
    logic [OWN_W-1:0]  owner_r, owner_nxt_s;
    logic              dram_req_r, dram_req_nxt_s;
    logic              dram_we_r, dram_we_nxt_s;
    logic [ADDR_W-1:0] dram_addr_r, dram_addr_nxt_s;
    logic [DATA_W-1:0] dram_wdata_r, dram_wdata_nxt_s;
    logic [3:0]        dram_wstrb_r, dram_wstrb_nxt_s;

    assign starve_s     = (starve_cnt_r == STARVE_MAX);
    assign starve_inc_s = starve_s ? STARVE_MAX : (starve_cnt_r + CNT_W'(1));

    mmu_arb_pick u_pick (
        .ptw_req  (bus.ptw_req),
        .dm_req   (bus.dm_req),
        .if_req   (bus.if_req),
        .ptw_lock (bus.ptw_lock),
        .starve   (starve_s),
        .owner    (pick_s)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: fixed one-cycle ISSUE and GUARD, WAIT until the controller frees up
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_s != OWN_NONE) begin
                    state_nxt_s = ARB_ISSUE;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_nxt_s = ARB_GUARD;
            ARB_GUARD: state_nxt_s = ARB_WAIT;
            ARB_WAIT: begin
                if (!bus.dram_busy) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_WAIT;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Output next-values: grant/latch in IDLE, completion in WAIT, starvation bookkeeping
    always_comb begin
        ptw_ack_nxt_s    = 1'b0;
        dm_ack_nxt_s     = 1'b0;
        if_ack_nxt_s     = 1'b0;
        ptw_rvalid_nxt_s = 1'b0;
        dm_rvalid_nxt_s  = 1'b0;
        if_rvalid_nxt_s  = 1'b0;
        dram_req_nxt_s   = 1'b0;
        rdata_nxt_s      = rdata_r;
        owner_nxt_s      = owner_r;
        dram_we_nxt_s    = dram_we_r;
        dram_addr_nxt_s  = dram_addr_r;
        dram_wdata_nxt_s = dram_wdata_r;
        dram_wstrb_nxt_s = dram_wstrb_r;
        starve_cnt_nxt_s = starve_cnt_r;
        case (state_r)
            ARB_IDLE: begin
                case (pick_s)
                    OWN_PTW: begin
                        ptw_ack_nxt_s    = 1'b1;
                        dram_we_nxt_s    = bus.ptw_we;
                        dram_addr_nxt_s  = bus.ptw_addr;
                        dram_wdata_nxt_s = bus.ptw_wdata;
                        dram_wstrb_nxt_s = WSTRB_FULL;
                    end
                    OWN_DM: begin
                        dm_ack_nxt_s     = 1'b1;
                        dram_we_nxt_s    = bus.dm_we;
                        dram_addr_nxt_s  = bus.dm_addr;
                        dram_wdata_nxt_s = bus.dm_wdata;
                        dram_wstrb_nxt_s = bus.dm_wstrb;
                    end
                    OWN_IF: begin
                        if_ack_nxt_s     = 1'b1;
                        dram_we_nxt_s    = 1'b0;
                        dram_addr_nxt_s  = bus.if_addr;
                        dram_wdata_nxt_s = {DATA_W{1'b0}};
                        dram_wstrb_nxt_s = WSTRB_FULL;
                    end
                    default: begin
                    end
                endcase
                if (pick_s != OWN_NONE) begin
                    owner_nxt_s    = pick_s;
                    dram_req_nxt_s = 1'b1;
                end else begin
                    owner_nxt_s    = OWN_NONE;
                end
                // IF grants and an idle fetch port both forgive past DM wins
                if (pick_s == OWN_IF) begin
                    starve_cnt_nxt_s = {CNT_W{1'b0}};
                end else if ((pick_s == OWN_DM) && bus.if_req) begin
                    starve_cnt_nxt_s = starve_inc_s;
                end else if (!bus.if_req) begin
                    starve_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    starve_cnt_nxt_s = starve_cnt_r;
                end
            end
            ARB_ISSUE, ARB_GUARD: begin
            end
            ARB_WAIT: begin
                if (!bus.dram_busy) begin
                    rdata_nxt_s = bus.dram_odata;
                    owner_nxt_s = OWN_NONE;
                    case (owner_r)
                        OWN_PTW: ptw_rvalid_nxt_s = 1'b1;
                        OWN_DM:  dm_rvalid_nxt_s  = 1'b1;
                        OWN_IF:  if_rvalid_nxt_s  = 1'b1;
                        default: begin
                        end
                    endcase
                end else begin
                    owner_nxt_s = owner_r;
                end
            end
            default: begin
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptw_ack_r    <= 1'b0;
            dm_ack_r     <= 1'b0;
            if_ack_r     <= 1'b0;
            ptw_rvalid_r <= 1'b0;
            dm_rvalid_r  <= 1'b0;
            if_rvalid_r  <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            owner_r      <= OWN_NONE;
            dram_req_r   <= 1'b0;
            dram_we_r    <= 1'b0;
            dram_addr_r  <= {ADDR_W{1'b0}};
            dram_wdata_r <= {DATA_W{1'b0}};
            dram_wstrb_r <= 4'h0;
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            ptw_ack_r    <= ptw_ack_nxt_s;
            dm_ack_r     <= dm_ack_nxt_s;
            if_ack_r     <= if_ack_nxt_s;
            ptw_rvalid_r <= ptw_rvalid_nxt_s;
            dm_rvalid_r  <= dm_rvalid_nxt_s;
            if_rvalid_r  <= if_rvalid_nxt_s;
            rdata_r      <= rdata_nxt_s;
            owner_r      <= owner_nxt_s;
            dram_req_r   <= dram_req_nxt_s;
            dram_we_r    <= dram_we_nxt_s;
            dram_addr_r  <= dram_addr_nxt_s;
            dram_wdata_r <= dram_wdata_nxt_s;
            dram_wstrb_r <= dram_wstrb_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
        end
    end

    assign bus.ptw_ack    = ptw_ack_r;
    assign bus.dm_ack     = dm_ack_r;
    assign bus.if_ack     = if_ack_r;
    assign bus.ptw_rvalid = ptw_rvalid_r;
    assign bus.dm_rvalid  = dm_rvalid_r;
    assign bus.if_rvalid  = if_rvalid_r;
    assign bus.rdata      = rdata_r;
    assign bus.owner      = owner_r;
    assign bus.dram_req   = dram_req_r;
    assign bus.dram_we    = dram_we_r;
    assign bus.dram_addr  = dram_addr_r;
    assign bus.dram_wdata = dram_wdata_r;
    assign bus.dram_wstrb = dram_wstrb_r;

endmodule
